// File: rtl/mmio_pkg.sv
// Shared types and default addresses for the MMIO controller.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } mmio_state_e;

  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h0020_0000;
  localparam logic [31:0] FINISH_ADDR_DEF  = 32'h1000_0000;

endpackage

// File: rtl/mmio_con_fifo.sv
// Console byte FIFO: power-of-2 depth, accepts a push into a full FIFO only alongside a pop.
// Head is read from registered storage and forced to 0 while empty.
module mmio_con_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO frees the head slot on the same edge it is popped.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_ctrl.sv
// MMIO decode on the DCCM write port, console FIFO, shutdown sequencing and retirement watchdog.
// Optional watchdog: define MMIO_WDOG_EN to build the counter and TIMEOUT path.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] CONSOLE_ADDR = XLEN'(CONSOLE_ADDR_DEF),
  parameter logic [XLEN-1:0] FINISH_ADDR  = XLEN'(FINISH_ADDR_DEF),
  parameter int              FIFO_DEPTH   = 8,
  parameter int              WDOG_LIMIT   = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dccm_wen,
  input  logic [XLEN-1:0] dccm_waddr,
  input  logic [XLEN-1:0] dccm_wdata,
  input  logic            retire_valid,
  output logic            mmio_hit,
  output logic            con_valid,
  output logic [7:0]      con_data,
  input  logic            con_ready,
  output logic            con_overflow,
  output logic            halt_req,
  output logic            halted,
  output logic [XLEN-1:0] halt_code,
  output logic            wdog_timeout
);

  mmio_state_e state;
  logic        con_hit;
  logic        fin_hit;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        wdog_expire;

  assign con_hit  = dccm_wen && (dccm_waddr == CONSOLE_ADDR);
  assign fin_hit  = dccm_wen && (dccm_waddr == FINISH_ADDR);
  assign mmio_hit = con_hit | fin_hit;

  // Console bytes are only accepted while running; the FIFO drains in every state.
  assign push      = con_hit && (state == ST_RUN);
  assign con_valid = ~fifo_empty;
  assign pop       = con_valid & con_ready;

  mmio_con_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (dccm_wdata[7:0]),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (con_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      con_overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      con_overflow <= 1'b1;
    end
  end

`ifdef MMIO_WDOG_EN
  localparam int WCW = $clog2(WDOG_LIMIT + 1);

  logic [WCW-1:0] wdog_cnt;

  assign wdog_expire = (state == ST_RUN) && !retire_valid &&
                       (wdog_cnt == WCW'(WDOG_LIMIT - 1));

  // Reaches at most WDOG_LIMIT on the expiring edge, then freezes outside RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
    end else if (state == ST_RUN) begin
      wdog_cnt <= retire_valid ? '0 : wdog_cnt + WCW'(1);
    end
  end
`else
  localparam int unused_wdog_limit = WDOG_LIMIT;
  logic unused_retire;

  assign unused_retire = retire_valid;
  assign wdog_expire   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      halt_req     <= 1'b0;
      halted       <= 1'b0;
      halt_code    <= '0;
      wdog_timeout <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (fin_hit) begin
            state     <= ST_DRAIN;
            halt_req  <= 1'b1;
            halt_code <= dccm_wdata;
          end else if (wdog_expire) begin
            state        <= ST_TIMEOUT;
            halt_req     <= 1'b1;
            wdog_timeout <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Bench for mmio_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_mmio_ctrl;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 8;
  localparam int          LIMIT = 16;
  localparam logic [31:0] CON   = 32'h0020_0000;
  localparam logic [31:0] FIN   = 32'h1000_0000;
  localparam int P_RUN = 0, P_DRAIN = 1, P_DONE = 2, P_TO = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            dccm_wen;
  logic [XLEN-1:0] dccm_waddr;
  logic [XLEN-1:0] dccm_wdata;
  logic            retire_valid;
  logic            mmio_hit;
  logic            con_valid;
  logic [7:0]      con_data;
  logic            con_ready;
  logic            con_overflow;
  logic            halt_req;
  logic            halted;
  logic [XLEN-1:0] halt_code;
  logic            wdog_timeout;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  q[$];
  bit          m_ovf, m_hreq, m_halted, m_wd;
  logic [31:0] m_code;
  int          m_phase, m_idle;

  mmio_ctrl #(
    .XLEN        (XLEN),
    .CONSOLE_ADDR(CON),
    .FINISH_ADDR (FIN),
    .FIFO_DEPTH  (DEPTH),
    .WDOG_LIMIT  (LIMIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dccm_wen    (dccm_wen),
    .dccm_waddr  (dccm_waddr),
    .dccm_wdata  (dccm_wdata),
    .retire_valid(retire_valid),
    .mmio_hit    (mmio_hit),
    .con_valid   (con_valid),
    .con_data    (con_data),
    .con_ready   (con_ready),
    .con_overflow(con_overflow),
    .halt_req    (halt_req),
    .halted      (halted),
    .halt_code   (halt_code),
    .wdog_timeout(wdog_timeout)
  );

  always #5 clk = ~clk;

  task automatic drive(input bit wen, input logic [31:0] a, input logic [31:0] d,
                       input bit rdy, input bit ret);
    dccm_wen     = wen;
    dccm_waddr   = a;
    dccm_wdata   = d;
    con_ready    = rdy;
    retire_valid = ret;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    bit fin, con, pop, was_empty, run;
    @(posedge clk);
    fin = dccm_wen && (dccm_waddr == FIN);
    con = dccm_wen && (dccm_waddr == CON);
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_hreq = 0; m_halted = 0; m_wd = 0; m_code = '0;
      m_phase = P_RUN; m_idle = 0;
    end else begin
      was_empty = (q.size() == 0);
      pop       = !was_empty && con_ready;
      run       = (m_phase == P_RUN);
      if (run) begin
        m_idle = retire_valid ? 0 : m_idle + 1;
        if (fin) begin
          m_phase = P_DRAIN; m_hreq = 1; m_code = dccm_wdata;
        end
`ifdef MMIO_WDOG_EN
        else if (m_idle >= LIMIT) begin
          m_phase = P_TO; m_hreq = 1; m_wd = 1;
        end
`endif
      end else if (m_phase == P_DRAIN && was_empty) begin
        m_phase = P_DONE; m_halted = 1;
      end
      if (pop) void'(q.pop_front());
      if (con && run) begin
        if (q.size() < DEPTH) q.push_back(dccm_wdata[7:0]);
        else m_ovf = 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    drive(0, '0, '0, 0, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (con_valid !== 1'b0) begin errors++; $display("FAIL reset_con_valid: got %b want 0", con_valid); end
    checks++; if (con_data !== 8'h00) begin errors++; $display("FAIL reset_con_data: got %h want 00", con_data); end
    checks++; if (con_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", con_overflow); end
    checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL reset_halt_req: got %b want 0", halt_req); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (halt_code !== 32'h0) begin errors++; $display("FAIL reset_halt_code: got %h want 0", halt_code); end
    checks++; if (wdog_timeout !== 1'b0) begin errors++; $display("FAIL reset_wdog: got %b want 0", wdog_timeout); end
    checks++; if (mmio_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", mmio_hit); end
  endtask

  task automatic test_console_hi();
    do_reset();
    drive(1, CON, 32'h0000_0048, 1, 1); #1;
    checks++; if (mmio_hit !== 1'b1) begin errors++; $display("FAIL hi_hit_h: got %b want 1", mmio_hit); end
    tick();
    checks++; if (con_valid !== 1'b1 || con_data !== 8'h48) begin errors++; $display("FAIL hi_data_h: got v=%b d=%h want v=1 d=48", con_valid, con_data); end
    drive(1, CON, 32'hFFFF_FF69, 1, 1); #1;
    checks++; if (mmio_hit !== 1'b1) begin errors++; $display("FAIL hi_hit_i: got %b want 1", mmio_hit); end
    tick();
    checks++; if (con_valid !== 1'b1 || con_data !== 8'h69) begin errors++; $display("FAIL hi_data_i: got v=%b d=%h want v=1 d=69", con_valid, con_data); end
    drive(1, CON + 32'd4, 32'h0000_0055, 1, 1); #1;
    checks++; if (mmio_hit !== 1'b0) begin errors++; $display("FAIL hi_near_miss_hit: got %b want 0", mmio_hit); end
    tick();
    drive(0, CON, 32'h0000_0077, 1, 1); #1;
    checks++; if (mmio_hit !== 1'b0) begin errors++; $display("FAIL hi_no_wen_hit: got %b want 0", mmio_hit); end
    tick();
    checks++; if (con_valid !== 1'b0 || con_data !== 8'h00) begin errors++; $display("FAIL hi_empty: got v=%b d=%h want v=0 d=00", con_valid, con_data); end
  endtask

  task automatic test_overflow();
    logic [7:0] b[9];
    do_reset();
    for (int i = 0; i < 9; i++) begin
      b[i] = 8'($urandom);
      drive(1, CON, {24'($urandom), b[i]}, 0, 1);
      tick();
    end
    checks++; if (con_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", con_overflow); end
    for (int i = 0; i < 8; i++) begin
      drive(0, '0, '0, 1, 1); #1;
      checks++; if (con_valid !== 1'b1 || con_data !== b[i]) begin errors++; $display("FAIL ovf_drain_%0d: got v=%b d=%h want v=1 d=%h", i, con_valid, con_data, b[i]); end
      tick();
    end
    checks++; if (con_valid !== 1'b0) begin errors++; $display("FAIL ovf_ninth_seen: got v=%b d=%h want v=0", con_valid, con_data); end
    checks++; if (con_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", con_overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] b[9];
    do_reset();
    for (int i = 0; i < 9; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      drive(1, CON, {24'h0, b[i]}, 0, 1);
      tick();
    end
    drive(1, CON, {24'h0, b[8]}, 1, 1);
    tick();
    checks++; if (con_overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow: got %b want 0", con_overflow); end
    for (int i = 1; i < 9; i++) begin
      drive(0, '0, '0, 1, 1); #1;
      checks++; if (con_valid !== 1'b1 || con_data !== b[i]) begin errors++; $display("FAIL fpp_order_%0d: got v=%b d=%h want v=1 d=%h", i, con_valid, con_data, b[i]); end
      tick();
    end
    checks++; if (con_valid !== 1'b0) begin errors++; $display("FAIL fpp_count: got v=%b want 0 after 8 pops", con_valid); end
  endtask

  task automatic test_finish_drain();
    logic [7:0] b[3];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      b[i] = 8'($urandom);
      drive(1, CON, {24'h0, b[i]}, 0, 1);
      tick();
    end
    drive(1, FIN, 32'h0000_002A, 0, 1); #1;
    checks++; if (mmio_hit !== 1'b1) begin errors++; $display("FAIL fin_hit: got %b want 1", mmio_hit); end
    tick();
    checks++; if (halt_req !== 1'b1 || halt_code !== 32'h2A || halted !== 1'b0) begin errors++; $display("FAIL fin_capture: got req=%b code=%h halted=%b want 1 2a 0", halt_req, halt_code, halted); end
    drive(1, CON, 32'h0000_005A, 0, 1); #1;
    checks++; if (mmio_hit !== 1'b1) begin errors++; $display("FAIL fin_drain_con_hit: got %b want 1", mmio_hit); end
    tick();
    drive(1, FIN, 32'h0000_0055, 0, 1);
    tick();
    checks++; if (halt_code !== 32'h2A) begin errors++; $display("FAIL fin_code_kept: got %h want 2a", halt_code); end
    drive(0, '0, '0, 0, 1);
    repeat (5) tick();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL fin_early_halt: got %b want 0", halted); end
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, '0, 1, 1); #1;
      checks++; if (con_data !== b[i]) begin errors++; $display("FAIL fin_pop_%0d: got %h want %h", i, con_data, b[i]); end
      tick();
    end
    checks++; if (halted !== 1'b0 || con_valid !== 1'b0) begin errors++; $display("FAIL fin_after_last_pop: got halted=%b v=%b want 0 0", halted, con_valid); end
    tick();
    checks++; if (halted !== 1'b1 || halt_req !== 1'b1) begin errors++; $display("FAIL fin_halted: got halted=%b req=%b want 1 1", halted, halt_req); end
  endtask

  task automatic test_watchdog();
`ifdef MMIO_WDOG_EN
    do_reset();
    drive(0, '0, '0, 0, 0);
    repeat (15) tick();
    checks++; if (wdog_timeout !== 1'b0) begin errors++; $display("FAIL wd_early_15: got %b want 0", wdog_timeout); end
    drive(0, '0, '0, 0, 1);
    tick();
    drive(0, '0, '0, 0, 0);
    repeat (15) tick();
    checks++; if (wdog_timeout !== 1'b0) begin errors++; $display("FAIL wd_restart: got %b want 0", wdog_timeout); end
    tick();
    checks++; if (wdog_timeout !== 1'b1 || halt_req !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL wd_fire: got to=%b req=%b halted=%b want 1 1 0", wdog_timeout, halt_req, halted); end
    drive(1, CON, 32'h0000_0011, 0, 0); #1;
    checks++; if (mmio_hit !== 1'b1) begin errors++; $display("FAIL wd_con_hit: got %b want 1", mmio_hit); end
    tick();
    checks++; if (con_valid !== 1'b0) begin errors++; $display("FAIL wd_push_ignored: got %b want 0", con_valid); end
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int n = 0; n < 80; n++) begin
        drive(0, '0, '0, 0, $urandom_range(0, 7) == 0);
        tick();
        checks++; if (wdog_timeout !== m_wd) begin errors++; $display("FAIL wd_rand_%0d_%0d: got %b want %b", r, n, wdog_timeout, m_wd); end
      end
    end
`else
    do_reset();
    drive(0, '0, '0, 0, 0);
    repeat (40) tick();
    checks++; if (wdog_timeout !== 1'b0 || halt_req !== 1'b0) begin errors++; $display("FAIL wd_disabled: got to=%b req=%b want 0 0", wdog_timeout, halt_req); end
`endif
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1, CON, $urandom, 0, 1);
      tick();
    end
    drive(1, FIN, 32'hDEAD_BEEF, 0, 1);
    tick();
    checks++; if (halt_req !== 1'b1 || con_overflow !== 1'b1) begin errors++; $display("FAIL rmd_setup: got req=%b ovf=%b want 1 1", halt_req, con_overflow); end
    do_reset();
    checks++; if (con_valid !== 1'b0 || con_data !== 8'h00) begin errors++; $display("FAIL rmd_fifo: got v=%b d=%h want 0 00", con_valid, con_data); end
    checks++; if (halt_req !== 1'b0 || halted !== 1'b0 || halt_code !== 32'h0) begin errors++; $display("FAIL rmd_halt: got req=%b halted=%b code=%h want 0 0 0", halt_req, halted, halt_code); end
    checks++; if (con_overflow !== 1'b0 || wdog_timeout !== 1'b0) begin errors++; $display("FAIL rmd_flags: got ovf=%b to=%b want 0 0", con_overflow, wdog_timeout); end
    drive(1, CON, 32'h0000_0033, 0, 1);
    tick();
    checks++; if (con_valid !== 1'b1 || con_data !== 8'h33) begin errors++; $display("FAIL rmd_run: got v=%b d=%h want 1 33", con_valid, con_data); end
  endtask

  task automatic test_random();
    bit          w, rdy, ret, exp_hit;
    int          r;
    logic [31:0] a;
    logic [7:0]  exp_d;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      w = $urandom_range(0, 9) < 7;
      r = $urandom_range(0, 31);
      a = (r == 0) ? FIN : (r < 20) ? CON : $urandom;
      rdy = $urandom_range(0, 1) == 1;
      ret = $urandom_range(0, 2) == 0;
      rst_n = $urandom_range(0, 49) != 0;
      drive(w, a, $urandom, rdy, ret); #1;
      exp_hit = w && (a == CON || a == FIN);
      checks++; if (mmio_hit !== exp_hit) begin errors++; $display("FAIL rand_hit_%0d: got %b want %b", n, mmio_hit, exp_hit); end
      tick();
      rst_n = 1'b1;
      exp_d = (q.size() != 0) ? q[0] : 8'h00;
      checks++; if (con_valid !== (q.size() != 0) || con_data !== exp_d) begin errors++; $display("FAIL rand_fifo_%0d: got v=%b d=%h want v=%b d=%h", n, con_valid, con_data, q.size() != 0, exp_d); end
      checks++; if (con_overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf_%0d: got %b want %b", n, con_overflow, m_ovf); end
      checks++; if (halt_req !== m_hreq || halted !== m_halted || wdog_timeout !== m_wd) begin errors++; $display("FAIL rand_ctrl_%0d: got req=%b halted=%b to=%b want %b %b %b", n, halt_req, halted, wdog_timeout, m_hreq, m_halted, m_wd); end
      checks++; if (halt_code !== m_code) begin errors++; $display("FAIL rand_code_%0d: got %h want %h", n, halt_code, m_code); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, '0, '0, 0, 1);
    q.delete();
    m_ovf = 0; m_hreq = 0; m_halted = 0; m_wd = 0; m_code = '0;
    m_phase = P_RUN; m_idle = 0;
    test_reset();
    test_console_hi();
    test_overflow();
    test_full_push_pop();
    test_finish_drain();
    test_watchdog();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
